bool_tt_sequencer: RTL

BOOL_TT_SEQUENCER -- requirements
Module: bool_tt_sequencer

---
 rtl/bool_tt_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/bool_tt_sequencer.sv
// Truth-table sequencer: drives the 8 input vectors of a 3-input Boolean function,
// waits for it to settle, captures d, and compares the result against a golden table.
module bool_tt_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch_mask
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic [7:0] expected_lat;

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign {a, b, c} = busy ? idx : 3'b000;

  // Abort is checked before the SAMPLE capture so an aborted vector is never recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      settle_cnt    <= 4'd0;
      expected_lat  <= 8'd0;
      done          <= 1'b0;
      pass          <= 1'b0;
      truth_table   <= 8'd0;
      mismatch_mask <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expected_lat  <= expected;
            truth_table   <= 8'd0;
            mismatch_mask <= 8'd0;
            pass          <= 1'b0;
            idx           <= 3'd0;
            settle_cnt    <= 4'd0;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            pass       <= 1'b0;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          if (abort) begin
            pass       <= 1'b0;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            state      <= IDLE;
          end else begin
            truth_table[idx] <= d;
            settle_cnt       <= 4'd0;
            if (idx == 3'd7) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          done          <= 1'b1;
          mismatch_mask <= truth_table ^ expected_lat;
          pass          <= ((truth_table ^ expected_lat) == 8'd0);
          idx           <= 3'd0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
